// File: rtl/tblink_rpc_cmd_bus_bridge_pkg.sv
// Shared command/status codes and response layout for the tblink RPC bus bridge.
package tblink_rpc_cmd_bus_bridge_pkg;

    localparam logic [7:0] CMD_WRITE = 8'd1;
    localparam logic [7:0] CMD_READ  = 8'd2;
    localparam logic [7:0] CMD_NOP   = 8'd3;

    // Param byte counts each known command must carry
    localparam logic [7:0] SZ_WRITE  = 8'd8;
    localparam logic [7:0] SZ_READ   = 8'd4;
    localparam logic [7:0] SZ_NOP    = 8'd0;

    localparam logic [7:0] STS_OK      = 8'd0;
    localparam logic [7:0] STS_BUS_ERR = 8'd1;
    localparam logic [7:0] STS_TIMEOUT = 8'd2;
    localparam logic [7:0] STS_BAD_CMD = 8'd3;
    localparam logic [7:0] STS_BAD_LEN = 8'd4;

    localparam logic [7:0] RSP_SZ_STATUS = 8'd1;
    localparam logic [7:0] RSP_SZ_READ   = 8'd5;

    // Low 5 response bytes: status byte above the 32-bit read data
    typedef struct packed {
        logic [7:0]  status;
        logic [31:0] rdata;
    } rsp_t;

endpackage

// File: rtl/tblink_rpc_cmd_bus_bridge_if.sv
// cmd_in toggle handshake plus single-master bus; master = bridge, slave = command/bus side.
interface tblink_rpc_cmd_bus_bridge_if #(
    parameter int P = 8,
    parameter int R = 5
);
    logic [7:0]     cmd_in;
    logic [7:0]     cmd_in_sz;
    logic [P*8-1:0] cmd_in_params;
    logic           cmd_in_put_i;
    logic           cmd_in_get_i;
    logic [R*8-1:0] cmd_in_rsp;
    logic [7:0]     cmd_in_rsp_sz;

    logic           bus_cyc_stb;
    logic           bus_we;
    logic [31:0]    bus_adr;
    logic [31:0]    bus_dat_w;
    logic [31:0]    bus_dat_r;
    logic           bus_ack;
    logic           bus_err;

    modport master (
        input  cmd_in, cmd_in_sz, cmd_in_params, cmd_in_put_i,
        output cmd_in_get_i, cmd_in_rsp, cmd_in_rsp_sz,
        output bus_cyc_stb, bus_we, bus_adr, bus_dat_w,
        input  bus_dat_r, bus_ack, bus_err
    );

    modport slave (
        output cmd_in, cmd_in_sz, cmd_in_params, cmd_in_put_i,
        input  cmd_in_get_i, cmd_in_rsp, cmd_in_rsp_sz,
        input  bus_cyc_stb, bus_we, bus_adr, bus_dat_w,
        output bus_dat_r, bus_ack, bus_err
    );

endinterface

// File: rtl/tblink_rpc_timeout_ctr.sv
// Bus wait counter; expired fires on the enabled cycle whose increment reaches limit.
// Only built when TBLINK_RPC_BUS_BRIDGE_TIMEOUT_EN is defined.
`ifdef TBLINK_RPC_BUS_BRIDGE_TIMEOUT_EN
module tblink_rpc_timeout_ctr (
    input  logic       uclock,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] limit,
    output logic       expired
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = 8'd0;
        end else if (enable) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // limit <= 255, so the increment never wraps before expiry
    assign expired = enable && !clear && ((cnt_q + 8'd1) == limit);

    always_ff @(posedge uclock or posedge reset) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/tblink_rpc_cmd_bus_bridge.sv
// Executes tblink RPC WRITE/READ/NOP as one bus transaction each; get toggles 3 edges after put (+ bus wait).
// One command outstanding; TBLINK_RPC_BUS_BRIDGE_TIMEOUT_EN bounds the bus wait to TIMEOUT_CYC cycles.
module tblink_rpc_cmd_bus_bridge
    import tblink_rpc_cmd_bus_bridge_pkg::*;
#(
    parameter int CMD_IN_PARAMS_SZ = 8,
    parameter int CMD_IN_RSP_SZ    = 5,
    parameter int TIMEOUT_CYC      = 255
) (
    input  logic                        uclock,
    input  logic                        reset,
    tblink_rpc_cmd_bus_bridge_if.master bif
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DECODE = 2'd1;
    localparam logic [1:0] S_BUS    = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    if (CMD_IN_PARAMS_SZ < 8 || CMD_IN_RSP_SZ < 5 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_param_check
        $error("tblink_rpc_cmd_bus_bridge: parameter out of range");
    end

    logic [1:0]  state_q,   state_d;
    logic        get_q,     get_d;
    logic [7:0]  cmd_q,     cmd_d;
    logic [7:0]  sz_q,      sz_d;
    logic [63:0] params_q,  params_d;
    logic        stb_q,     stb_d;
    logic        we_q,      we_d;
    logic [31:0] adr_q,     adr_d;
    logic [31:0] dat_w_q,   dat_w_d;
    rsp_t        rsp_q,     rsp_d;
    logic [7:0]  rsp_sz_q,  rsp_sz_d;

    logic        tmo_expired;

`ifdef TBLINK_RPC_BUS_BRIDGE_TIMEOUT_EN
    tblink_rpc_timeout_ctr u_timeout_ctr (
        .uclock  (uclock),
        .reset   (reset),
        .clear   (state_q != S_BUS),
        .enable  ((state_q == S_BUS) && !bif.bus_ack && !bif.bus_err),
        .limit   (8'(TIMEOUT_CYC)),
        .expired (tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        get_d    = get_q;
        cmd_d    = cmd_q;
        sz_d     = sz_q;
        params_d = params_q;
        stb_d    = stb_q;
        we_d     = we_q;
        adr_d    = adr_q;
        dat_w_d  = dat_w_q;
        rsp_d    = rsp_q;
        rsp_sz_d = rsp_sz_q;

        case (state_q)
            S_IDLE: begin
                if (bif.cmd_in_put_i != get_q) begin
                    cmd_d    = bif.cmd_in;
                    sz_d     = bif.cmd_in_sz;
                    params_d = bif.cmd_in_params[63:0];
                    state_d  = S_DECODE;
                end
            end

            S_DECODE: begin
                rsp_sz_d = RSP_SZ_STATUS;
                if (cmd_q == CMD_WRITE && sz_q == SZ_WRITE) begin
                    adr_d   = params_q[63:32];
                    dat_w_d = params_q[31:0];
                    we_d    = 1'b1;
                    stb_d   = 1'b1;
                    rsp_sz_d = rsp_sz_q;
                    state_d = S_BUS;
                end else if (cmd_q == CMD_READ && sz_q == SZ_READ) begin
                    adr_d   = params_q[31:0];
                    dat_w_d = 32'd0;
                    we_d    = 1'b0;
                    stb_d   = 1'b1;
                    rsp_sz_d = rsp_sz_q;
                    state_d = S_BUS;
                end else if (cmd_q == CMD_NOP && sz_q == SZ_NOP) begin
                    rsp_d   = '{status: STS_OK, rdata: 32'd0};
                    state_d = S_DONE;
                end else if (cmd_q == CMD_WRITE || cmd_q == CMD_READ || cmd_q == CMD_NOP) begin
                    rsp_d   = '{status: STS_BAD_LEN, rdata: 32'd0};
                    state_d = S_DONE;
                end else begin
                    rsp_d   = '{status: STS_BAD_CMD, rdata: 32'd0};
                    state_d = S_DONE;
                end
            end

            S_BUS: begin
                // err takes priority over a coincident ack
                if (bif.bus_err) begin
                    rsp_d    = '{status: STS_BUS_ERR, rdata: 32'd0};
                    rsp_sz_d = RSP_SZ_STATUS;
                    stb_d    = 1'b0;
                    state_d  = S_DONE;
                end else if (bif.bus_ack) begin
                    rsp_d    = '{status: STS_OK, rdata: we_q ? 32'd0 : bif.bus_dat_r};
                    rsp_sz_d = we_q ? RSP_SZ_STATUS : RSP_SZ_READ;
                    stb_d    = 1'b0;
                    state_d  = S_DONE;
                end else if (tmo_expired) begin
                    rsp_d    = '{status: STS_TIMEOUT, rdata: 32'd0};
                    rsp_sz_d = RSP_SZ_STATUS;
                    stb_d    = 1'b0;
                    state_d  = S_DONE;
                end
            end

            default: begin
                get_d   = ~get_q;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge uclock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            get_q    <= 1'b0;
            cmd_q    <= 8'd0;
            sz_q     <= 8'd0;
            params_q <= 64'd0;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= 32'd0;
            dat_w_q  <= 32'd0;
            rsp_q    <= '0;
            rsp_sz_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            get_q    <= get_d;
            cmd_q    <= cmd_d;
            sz_q     <= sz_d;
            params_q <= params_d;
            stb_q    <= stb_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            dat_w_q  <= dat_w_d;
            rsp_q    <= rsp_d;
            rsp_sz_q <= rsp_sz_d;
        end
    end

    assign bif.cmd_in_get_i  = get_q;
    assign bif.cmd_in_rsp    = (CMD_IN_RSP_SZ*8)'(rsp_q);
    assign bif.cmd_in_rsp_sz = rsp_sz_q;
    assign bif.bus_cyc_stb   = stb_q;
    assign bif.bus_we        = we_q;
    assign bif.bus_adr       = adr_q;
    assign bif.bus_dat_w     = dat_w_q;

endmodule

// File: tb/tb_tblink_rpc_cmd_bus_bridge.sv
// Scoreboarded bench for tblink_rpc_cmd_bus_bridge; timeout scenario follows TBLINK_RPC_BUS_BRIDGE_TIMEOUT_EN.
module tb_tblink_rpc_cmd_bus_bridge;

    localparam int TMO = 10;

    logic uclock = 1'b0;
    logic reset  = 1'b1;
    always #5 uclock = ~uclock;

    tblink_rpc_cmd_bus_bridge_if #(.P(8), .R(5)) bif ();

    tblink_rpc_cmd_bus_bridge #(
        .CMD_IN_PARAMS_SZ (8),
        .CMD_IN_RSP_SZ    (5),
        .TIMEOUT_CYC      (TMO)
    ) dut (
        .uclock (uclock),
        .reset  (reset),
        .bif    (bif)
    );

    int total = 0;
    int bad   = 0;

    logic [39:0] exp_rsp_q[$];
    logic [7:0]  exp_sz_q[$];
    logic        prev_get = 1'b0;
    logic [39:0] mon_rsp;
    logic [7:0]  mon_sz;

    // Scoreboard: every get toggle retires the oldest expected response
    always @(negedge uclock) begin
        if (reset) begin
            prev_get = 1'b0;
        end else if (bif.cmd_in_get_i !== prev_get) begin
            prev_get = bif.cmd_in_get_i;
            total++;
            if (exp_rsp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: get toggled to %0b with no command pending", bif.cmd_in_get_i);
            end else begin
                mon_rsp = exp_rsp_q.pop_front();
                mon_sz  = exp_sz_q.pop_front();
                if (bif.cmd_in_rsp !== mon_rsp) begin
                    bad++;
                    $display("FAIL sb_rsp: got %h want %h", bif.cmd_in_rsp, mon_rsp);
                end
                total++;
                if (bif.cmd_in_rsp_sz !== mon_sz) begin
                    bad++;
                    $display("FAIL sb_rsp_sz: got %0d want %0d", bif.cmd_in_rsp_sz, mon_sz);
                end
            end
        end
    end

    task automatic send(input logic [7:0] cmd, input logic [7:0] sz, input logic [63:0] params,
                        input logic [39:0] exp_rsp, input logic [7:0] exp_sz);
        @(negedge uclock);
        bif.cmd_in        = cmd;
        bif.cmd_in_sz     = sz;
        bif.cmd_in_params = params;
        bif.cmd_in_put_i  = ~bif.cmd_in_put_i;
        exp_rsp_q.push_back(exp_rsp);
        exp_sz_q.push_back(exp_sz);
    endtask

    task automatic wait_done(input string name, input int budget, output int cyc, output logic saw_stb);
        cyc = 0;
        saw_stb = 1'b0;
        while (bif.cmd_in_get_i !== bif.cmd_in_put_i && cyc < budget) begin
            @(negedge uclock);
            cyc++;
            saw_stb |= bif.bus_cyc_stb;
        end
        if (bif.cmd_in_get_i !== bif.cmd_in_put_i) begin
            total++;
            bad++;
            $display("FAIL %s_done_timeout: get=%0b put=%0b after %0d cycles", name,
                     bif.cmd_in_get_i, bif.cmd_in_put_i, cyc);
        end
    endtask

    task automatic wait_stb(input string name, input int budget);
        int cyc = 0;
        while (bif.bus_cyc_stb !== 1'b1 && cyc < budget) begin
            @(negedge uclock);
            cyc++;
        end
        if (bif.bus_cyc_stb !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL %s_stb_timeout: stb=%0b after %0d cycles", name, bif.bus_cyc_stb, cyc);
        end
    endtask

    task automatic test_reset();
        bif.cmd_in = 8'd0; bif.cmd_in_sz = 8'd0; bif.cmd_in_params = 64'd0; bif.cmd_in_put_i = 1'b0;
        bif.bus_dat_r = 32'd0; bif.bus_ack = 1'b0; bif.bus_err = 1'b0;
        reset = 1'b1;
        @(negedge uclock);
        total++; if (bif.bus_cyc_stb !== 1'b0)   begin bad++; $display("FAIL reset_stb: got %0b want 0", bif.bus_cyc_stb); end
        total++; if (bif.cmd_in_get_i !== 1'b0)  begin bad++; $display("FAIL reset_get: got %0b want 0", bif.cmd_in_get_i); end
        total++; if (bif.cmd_in_rsp !== 40'd0)   begin bad++; $display("FAIL reset_rsp: got %h want 0", bif.cmd_in_rsp); end
        total++; if (bif.cmd_in_rsp_sz !== 8'd0) begin bad++; $display("FAIL reset_rsp_sz: got %0d want 0", bif.cmd_in_rsp_sz); end
        total++; if ({bif.bus_we, bif.bus_adr, bif.bus_dat_w} !== 65'd0) begin
            bad++; $display("FAIL reset_bus: we=%0b adr=%h dat_w=%h want all 0", bif.bus_we, bif.bus_adr, bif.bus_dat_w);
        end
        #1 reset = 1'b0;
    endtask

    task automatic test_write();
        int cyc; logic s;
        send(8'd1, 8'd8, 64'h0000_1000_DEAD_BEEF, {8'd0, 32'd0}, 8'd1);
        wait_stb("write", 10);
        total++; if (bif.bus_adr !== 32'h1000)       begin bad++; $display("FAIL write_adr: got %h want 00001000", bif.bus_adr); end
        total++; if (bif.bus_dat_w !== 32'hDEADBEEF) begin bad++; $display("FAIL write_dat: got %h want deadbeef", bif.bus_dat_w); end
        total++; if (bif.bus_we !== 1'b1)            begin bad++; $display("FAIL write_we: got %0b want 1", bif.bus_we); end
        @(negedge uclock);
        @(negedge uclock);
        bif.bus_ack = 1'b1;
        @(negedge uclock);
        bif.bus_ack = 1'b0;
        total++; if (bif.bus_cyc_stb !== 1'b0) begin bad++; $display("FAIL write_stb_drop: got %0b want 0", bif.bus_cyc_stb); end
        wait_done("write", 10, cyc, s);
    endtask

    task automatic test_read();
        int cyc; logic s;
        send(8'd2, 8'd4, 64'hFFFF_FFFF_0000_0020, {8'd0, 32'h12345678}, 8'd5);
        wait_stb("read", 10);
        total++; if (bif.bus_we !== 1'b0)      begin bad++; $display("FAIL read_we: got %0b want 0", bif.bus_we); end
        total++; if (bif.bus_adr !== 32'h20)   begin bad++; $display("FAIL read_adr: got %h want 00000020", bif.bus_adr); end
        @(negedge uclock);
        bif.bus_dat_r = 32'h12345678;
        bif.bus_ack   = 1'b1;
        @(negedge uclock);
        bif.bus_ack   = 1'b0;
        bif.bus_dat_r = 32'h0;
        wait_done("read", 10, cyc, s);
    endtask

    task automatic test_errors();
        int cyc; logic s;
        send(8'd9, 8'd0, 64'd0, {8'd3, 32'd0}, 8'd1);
        wait_done("bad_cmd", 20, cyc, s);
        total++; if (s !== 1'b0) begin bad++; $display("FAIL bad_cmd_stb: stb seen=%0b want 0", s); end
        send(8'd1, 8'd4, 64'h0000_2000_0000_0001, {8'd4, 32'd0}, 8'd1);
        wait_done("bad_len", 20, cyc, s);
        total++; if (s !== 1'b0) begin bad++; $display("FAIL bad_len_stb: stb seen=%0b want 0", s); end
        send(8'd3, 8'd2, 64'd0, {8'd4, 32'd0}, 8'd1);
        wait_done("nop_len", 20, cyc, s);
        send(8'd2, 8'd4, 64'h44, {8'd1, 32'd0}, 8'd1);
        wait_stb("ack_err", 10);
        @(negedge uclock);
        bif.bus_dat_r = 32'hFFFF_FFFF;
        bif.bus_ack = 1'b1;
        bif.bus_err = 1'b1;
        @(negedge uclock);
        bif.bus_ack = 1'b0;
        bif.bus_err = 1'b0;
        bif.bus_dat_r = 32'h0;
        wait_done("ack_err", 10, cyc, s);
    endtask

    task automatic test_nop_latency(input string name);
        int cyc; logic s;
        send(8'd3, 8'd0, 64'd0, {8'd0, 32'd0}, 8'd1);
        wait_done(name, 20, cyc, s);
        total++; if (cyc !== 3) begin bad++; $display("FAIL %s_latency: got %0d cycles want 3", name, cyc); end
    endtask

    task automatic test_bus_wait();
        int cyc; logic s;
`ifdef TBLINK_RPC_BUS_BRIDGE_TIMEOUT_EN
        int hi;
        send(8'd1, 8'd8, 64'h0000_3000_0000_0055, {8'd2, 32'd0}, 8'd1);
        wait_stb("timeout", 10);
        hi = 1;
        while (bif.bus_cyc_stb === 1'b1 && hi < 100) begin
            @(negedge uclock);
            if (bif.bus_cyc_stb === 1'b1) hi++;
        end
        total++; if (hi !== TMO) begin bad++; $display("FAIL timeout_stb_cycles: got %0d want %0d", hi, TMO); end
        wait_done("timeout", 10, cyc, s);
        repeat (3) begin
            @(negedge uclock);
            bif.bus_ack = 1'b1;
        end
        @(negedge uclock);
        bif.bus_ack = 1'b0;
        repeat (5) @(negedge uclock);
        total++; if (bif.bus_cyc_stb !== 1'b0) begin bad++; $display("FAIL late_ack_stb: got %0b want 0", bif.bus_cyc_stb); end
        total++; if (bif.cmd_in_get_i !== bif.cmd_in_put_i) begin
            bad++; $display("FAIL late_ack_get: get=%0b put=%0b", bif.cmd_in_get_i, bif.cmd_in_put_i);
        end
`else
        send(8'd2, 8'd4, 64'h30, {8'd0, 32'hCAFE_F00D}, 8'd5);
        wait_stb("no_timeout", 10);
        repeat (1000) @(negedge uclock);
        total++; if (bif.bus_cyc_stb !== 1'b1) begin bad++; $display("FAIL no_timeout_stb: got %0b want 1", bif.bus_cyc_stb); end
        total++; if (bif.cmd_in_get_i === bif.cmd_in_put_i) begin bad++; $display("FAIL no_timeout_get: completed without ack"); end
        bif.bus_dat_r = 32'hCAFE_F00D;
        bif.bus_ack   = 1'b1;
        @(negedge uclock);
        bif.bus_ack   = 1'b0;
        bif.bus_dat_r = 32'h0;
        wait_done("no_timeout", 10, cyc, s);
`endif
    endtask

    task automatic test_reset_mid();
        send(8'd1, 8'd8, 64'h0000_4000_1111_2222, {8'd0, 32'd0}, 8'd1);
        wait_stb("reset_mid", 10);
        #2 reset = 1'b1;
        #1;
        total++; if (bif.bus_cyc_stb !== 1'b0)  begin bad++; $display("FAIL reset_mid_stb: got %0b want 0", bif.bus_cyc_stb); end
        total++; if (bif.cmd_in_get_i !== 1'b0) begin bad++; $display("FAIL reset_mid_get: got %0b want 0", bif.cmd_in_get_i); end
        total++; if (bif.cmd_in_rsp !== 40'd0)  begin bad++; $display("FAIL reset_mid_rsp: got %h want 0", bif.cmd_in_rsp); end
        bif.cmd_in_put_i = 1'b0;
        exp_rsp_q.delete();
        exp_sz_q.delete();
        @(negedge uclock);
        #1 reset = 1'b0;
        test_nop_latency("after_reset");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_errors();
        test_nop_latency("nop");
        test_bus_wait();
        test_reset_mid();
        repeat (3) @(negedge uclock);
        total++;
        if (exp_rsp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: %0d responses never arrived, want 0", exp_rsp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
